// File: rtl/fetch_ctrl_if.sv
// Bundle of signals between the fetch controller and the IF/EX pipeline
// stages. The pipeline side drives the PC, predecode, stall and branch
// resolution inputs. The controller side returns the IF PC-select controls.
interface fetch_ctrl_if #(
    parameter int XLEN = 32
);
    // IF-stage view
    logic [XLEN-1:0] if_pc;
    logic            if_is_branch;
    logic [XLEN-1:0] if_branch_target;

    // Stall sources
    logic            load_use;
    logic            imem_ready;

    // Branch resolution from EX
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic            ex_taken;
    logic [XLEN-1:0] ex_target;
    logic            ex_pred;

    // PC-select controls back to IF
    logic            NOP;
    logic            flush;
    logic            prediction;
    logic [XLEN-1:0] pc_branch;
    logic [XLEN-1:0] control_pc;
    logic [15:0]     mispredict_cnt;

    // Pipeline side: drives fetch/EX state, consumes PC-select controls
    modport master (
        output if_pc, if_is_branch, if_branch_target,
        output load_use, imem_ready,
        output ex_valid, ex_pc, ex_taken, ex_target, ex_pred,
        input  NOP, flush, prediction, pc_branch, control_pc, mispredict_cnt
    );

    // Controller side: consumes fetch/EX state, produces PC-select controls
    modport slave (
        input  if_pc, if_is_branch, if_branch_target,
        input  load_use, imem_ready,
        input  ex_valid, ex_pc, ex_taken, ex_target, ex_pred,
        output NOP, flush, prediction, pc_branch, control_pc, mispredict_cnt
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch controller: sequences IF's PC-select inputs from a 2-bit saturating
// branch history table, EX branch resolution and stall requests.
// After reset the BHT is walked and cleared to weakly-not-taken while IF
// is held stalled. A mispredict produces a single FLUSH cycle that makes IF
// load the registered recovery PC.
module fetch_ctrl #(
    parameter int XLEN  = 32,
    parameter int IDX_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.slave  bus
);

    localparam int               BHT_DEPTH = 2 ** IDX_W;
    localparam logic [IDX_W-1:0] IDX_LAST  = {IDX_W{1'b1}};
    localparam logic [XLEN-1:0]  PC_STEP   = {{(XLEN-3){1'b0}}, 3'd4};

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Next value of a 2-bit saturating counter after one resolved outcome
    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        if (taken) begin
            if (ctr == 2'b11) begin
                res = 2'b11;
            end else begin
                res = ctr + 2'b01;
            end
        end else begin
            if (ctr == 2'b00) begin
                res = 2'b00;
            end else begin
                res = ctr - 2'b01;
            end
        end
        return res;
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic [IDX_W-1:0] init_idx_r;
    logic [1:0]       bht_r [BHT_DEPTH];

    logic [XLEN-1:0]  control_pc_r;
    logic [15:0]      mispredict_cnt_r;

    logic [IDX_W-1:0] if_idx_s;
    logic [IDX_W-1:0] ex_idx_s;
    logic [1:0]       bht_rd_s;
    logic             stall_s;

    logic             nop_s;
    logic             flush_s;
    logic             pred_s;
    logic             mispredict_s;
    logic             bht_we_s;
    logic [IDX_W-1:0] bht_widx_s;
    logic [1:0]       bht_wdata_s;

    assign if_idx_s = bus.if_pc[IDX_W+1:2];
    assign ex_idx_s = bus.ex_pc[IDX_W+1:2];
    // Combinational read sees the pre-update value on a same-cycle write
    assign bht_rd_s = bht_r[if_idx_s];
    assign stall_s  = bus.load_use | ~bus.imem_ready;

    // Next-state, IF controls and BHT write port, with defaults assigned first
    always_comb begin
        state_next_s = state_r;
        nop_s        = 1'b0;
        flush_s      = 1'b0;
        pred_s       = 1'b0;
        mispredict_s = 1'b0;
        bht_we_s     = 1'b0;
        bht_widx_s   = {IDX_W{1'b0}};
        bht_wdata_s  = 2'b00;
        case (state_r)
            ST_INIT: begin
                // Clearing the table; EX results are meaningless here
                nop_s       = 1'b1;
                bht_we_s    = 1'b1;
                bht_widx_s  = init_idx_r;
                bht_wdata_s = 2'b01;
                if (init_idx_r == IDX_LAST) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_INIT;
                end
            end
            ST_RUN: begin
                nop_s  = stall_s;
                // A stall outranks prediction in IF, so suppress it
                pred_s = bus.if_is_branch & bht_rd_s[1] & ~stall_s;
                if (bus.ex_valid) begin
                    bht_we_s     = 1'b1;
                    bht_widx_s   = ex_idx_s;
                    bht_wdata_s  = sat_update(bht_r[ex_idx_s], bus.ex_taken);
                    mispredict_s = (bus.ex_taken != bus.ex_pred);
                end else begin
                    bht_we_s     = 1'b0;
                    mispredict_s = 1'b0;
                end
                if (mispredict_s) begin
                    state_next_s = ST_FLUSH;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                // Flush wins in IF; a pending stall is applied in the next RUN cycle
                flush_s      = 1'b1;
                state_next_s = ST_RUN;
            end
            default: begin
                nop_s        = 1'b1;
                state_next_s = ST_INIT;
            end
        endcase
    end

    // State register; reset always restarts the table walk
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Walk index for the post-reset table clear
    always_ff @(posedge clk) begin
        if (rst) begin
            init_idx_r <= {IDX_W{1'b0}};
        end else if (state_r == ST_INIT) begin
            init_idx_r <= init_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
        end else begin
            init_idx_r <= {IDX_W{1'b0}};
        end
    end

    // BHT storage; contents are rebuilt by the INIT walk so no reset is needed
    always_ff @(posedge clk) begin
        if (bht_we_s && !rst) begin
            bht_r[bht_widx_s] <= bht_wdata_s;
        end
    end

    // Recovery PC and mispredict counter, captured on a RUN-state mispredict
    always_ff @(posedge clk) begin
        if (rst) begin
            control_pc_r     <= {XLEN{1'b0}};
            mispredict_cnt_r <= 16'h0000;
        end else if (mispredict_s) begin
            control_pc_r     <= bus.ex_taken ? bus.ex_target : (bus.ex_pc + PC_STEP);
            mispredict_cnt_r <= mispredict_cnt_r + 16'h0001;
        end else begin
            control_pc_r     <= control_pc_r;
            mispredict_cnt_r <= mispredict_cnt_r;
        end
    end

    assign bus.NOP            = nop_s;
    assign bus.flush          = flush_s;
    assign bus.prediction     = pred_s;
    assign bus.pc_branch      = bus.if_branch_target;
    assign bus.control_pc     = control_pc_r;
    assign bus.mispredict_cnt = mispredict_cnt_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: the stimulus process pushes the
// hand-computed expected IF controls for every cycle it drives; a monitor
// on the falling edge pops and compares against the DUT.
module tb_fetch_ctrl;

    logic clk;
    logic rst;

    fetch_ctrl_if #(.XLEN(32)) bus ();

    fetch_ctrl #(.XLEN(32), .IDX_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        string       name;
        logic        nop;
        logic        fl;
        logic        pr;
        logic [31:0] pcb;
        logic [31:0] cpc;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   tests_run = 0;
    int   tests_failed = 0;
    bit   stim_done = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Push one expectation for the current cycle and advance one clock
    task automatic expect_cycle(input string nm, input logic nop, input logic fl,
                                input logic pr, input logic [31:0] cpc,
                                input logic [15:0] cnt);
        exp_t e;
        e.name = nm;
        e.nop  = nop;
        e.fl   = fl;
        e.pr   = pr;
        e.pcb  = bus.if_branch_target;
        e.cpc  = cpc;
        e.cnt  = cnt;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [31:0] pc, input logic tk,
                          input logic [31:0] tgt, input logic pd);
        bus.ex_valid  = v;
        bus.ex_pc     = pc;
        bus.ex_taken  = tk;
        bus.ex_target = tgt;
        bus.ex_pred   = pd;
    endtask

    task automatic set_if(input logic [31:0] pc, input logic br, input logic [31:0] tgt);
        bus.if_pc            = pc;
        bus.if_is_branch     = br;
        bus.if_branch_target = tgt;
    endtask

    // Monitor: compare DUT outputs mid-cycle against the oldest expectation
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            tests_run = tests_run + 1;
            if (bus.NOP !== e.nop || bus.flush !== e.fl || bus.prediction !== e.pr ||
                bus.pc_branch !== e.pcb || bus.control_pc !== e.cpc ||
                bus.mispredict_cnt !== e.cnt) begin
                tests_failed = tests_failed + 1;
                $display("FAIL %s: got nop=%b flush=%b pred=%b pcb=%h cpc=%h cnt=%h, want nop=%b flush=%b pred=%b pcb=%h cpc=%h cnt=%h",
                         e.name, bus.NOP, bus.flush, bus.prediction, bus.pc_branch,
                         bus.control_pc, bus.mispredict_cnt,
                         e.nop, e.fl, e.pr, e.pcb, e.cpc, e.cnt);
            end
        end
    end

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: stimulus did not complete within time limit");
        $fatal(1, "timeout");
    end

    // Directed stimulus with hand-computed expectations
    initial begin
        rst = 1'b1;
        set_if(32'h0, 1'b0, 32'h0);
        set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        bus.load_use   = 1'b0;
        bus.imem_ready = 1'b1;
        @(posedge clk);
        #1;
        // Second reset cycle: reset values visible
        expect_cycle("reset", 1'b1, 1'b0, 1'b0, 32'h0, 16'h0);
        rst = 1'b0;
        // INIT lasts 16 cycles; a mispredicting EX result must be ignored
        set_ex(1'b1, 32'd100, 1'b1, 32'd200, 1'b0);
        for (int i = 0; i < 16; i++) begin
            expect_cycle($sformatf("init%0d", i), 1'b1, 1'b0, 1'b0, 32'h0, 16'h0);
        end
        set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        expect_cycle("run_first", 1'b0, 1'b0, 1'b0, 32'h0, 16'h0);

        // Training: taken mispredict at pc 100 (idx 9): 01 -> 10
        set_ex(1'b1, 32'd100, 1'b1, 32'd200, 1'b0);
        expect_cycle("train_ex", 1'b0, 1'b0, 1'b0, 32'h0, 16'h0);
        set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        expect_cycle("train_flush", 1'b0, 1'b1, 1'b0, 32'd200, 16'd1);
        set_if(32'd100, 1'b1, 32'd200);
        expect_cycle("pred_taken", 1'b0, 1'b0, 1'b1, 32'd200, 16'd1);
        // Three correct taken updates: 10 -> 11 -> 11 -> 11 (read sees old value)
        set_ex(1'b1, 32'd100, 1'b1, 32'd200, 1'b1);
        for (int i = 0; i < 3; i++) begin
            expect_cycle($sformatf("sat_up%0d", i), 1'b0, 1'b0, 1'b1, 32'd200, 16'd1);
        end

        // Not-taken mispredict: 11 -> 10, recovery to pc+4
        set_ex(1'b1, 32'd100, 1'b0, 32'd200, 1'b1);
        expect_cycle("nt_ex", 1'b0, 1'b0, 1'b1, 32'd200, 16'd1);
        // ex_valid still mispredicting during FLUSH: ignored
        expect_cycle("nt_flush", 1'b0, 1'b1, 1'b0, 32'd104, 16'd2);
        set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        expect_cycle("nt_after", 1'b0, 1'b0, 1'b1, 32'd104, 16'd2);

        // Stalls suppress prediction
        bus.load_use = 1'b1;
        expect_cycle("stall_lu", 1'b1, 1'b0, 1'b0, 32'd104, 16'd2);
        bus.load_use   = 1'b0;
        bus.imem_ready = 1'b0;
        expect_cycle("stall_imem", 1'b1, 1'b0, 1'b0, 32'd104, 16'd2);
        bus.imem_ready = 1'b1;
        expect_cycle("stall_release", 1'b0, 1'b0, 1'b1, 32'd104, 16'd2);

        // Index 0 (pc 0x40): down-saturation 01 -> 00 -> 00, then up 00 -> 01 -> 10
        set_if(32'h40, 1'b1, 32'h80);
        set_ex(1'b1, 32'h40, 1'b0, 32'h80, 1'b0);
        expect_cycle("dn0", 1'b0, 1'b0, 1'b0, 32'd104, 16'd2);
        expect_cycle("dn1", 1'b0, 1'b0, 1'b0, 32'd104, 16'd2);
        set_ex(1'b1, 32'h40, 1'b1, 32'h80, 1'b1);
        expect_cycle("up0", 1'b0, 1'b0, 1'b0, 32'd104, 16'd2);
        expect_cycle("up1", 1'b0, 1'b0, 1'b0, 32'd104, 16'd2);
        set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        expect_cycle("up_done", 1'b0, 1'b0, 1'b1, 32'd104, 16'd2);

        // Simultaneous flush and stall: idx 0 10 -> 01, recovery 0x44
        set_if(32'h0, 1'b0, 32'h0);
        set_ex(1'b1, 32'h40, 1'b0, 32'h80, 1'b1);
        expect_cycle("sim_ex", 1'b0, 1'b0, 1'b0, 32'd104, 16'd2);
        set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        bus.load_use = 1'b1;
        expect_cycle("sim_flush", 1'b0, 1'b1, 1'b0, 32'h44, 16'd3);
        expect_cycle("sim_stall", 1'b1, 1'b0, 1'b0, 32'h44, 16'd3);
        bus.load_use = 1'b0;

        // Reset during FLUSH: taken mispredict at idx 0 first
        set_ex(1'b1, 32'h40, 1'b1, 32'h300, 1'b0);
        expect_cycle("rf_ex", 1'b0, 1'b0, 1'b0, 32'h44, 16'd3);
        set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        expect_cycle("rf_flush", 1'b0, 1'b1, 1'b0, 32'h300, 16'd4);
        rst = 1'b0;
        set_if(32'd100, 1'b1, 32'd200);
        for (int i = 0; i < 16; i++) begin
            expect_cycle($sformatf("reinit%0d", i), 1'b1, 1'b0, 1'b0, 32'h0, 16'h0);
        end
        // Previously trained-taken entry was cleared by the walk
        expect_cycle("post_reinit", 1'b0, 1'b0, 1'b0, 32'h0, 16'h0);
        set_if(32'h0, 1'b0, 32'h0);

        @(negedge clk);
        #1;
        stim_done = 1'b1;
        if (q.size() != 0) begin
            tests_failed = tests_failed + 1;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Controller that sequences the IF stage's PC-select inputs. It drives IF's `NOP`, `flush`, `prediction`, `pc_branch` and `control_pc` from three sources:
- a 2-bit saturating branch history table (BHT);
- branch resolution from EX;
- stall requests from hazard detection and instruction memory.

After reset it walks the BHT to clear it while holding IF stalled.

## Interface
Parameters:
- `XLEN`, 32, PC width.
- `IDX_W`, 4, BHT index width; BHT has 2^IDX_W entries, indexed by `pc[IDX_W+1:2]`.

Ports:
- `clk` input 1: clock.
- `rst` input 1: reset. Single clock `clk`; reset `rst` is synchronous and active-high.
- `if_pc` input XLEN: current PC from IF (`cpc`).
- `if_is_branch` input 1: predecode says the instruction at `if_pc` is a conditional branch.
- `if_branch_target` input XLEN: predecoded target of that branch.
- `load_use` input 1: hazard unit requests a fetch stall.
- `imem_ready` input 1: instruction memory ready; 0 stalls fetch.
- `ex_valid` input 1: a conditional branch resolves in EX this cycle.
- `ex_pc` input XLEN: PC of the resolving branch.
- `ex_taken` input 1: actual outcome.
- `ex_target` input XLEN: actual taken target.
- `ex_pred` input 1: prediction made for that branch at fetch, piped down.
- `NOP` output 1: IF holds PC.
- `flush` output 1: IF loads `control_pc`.
- `prediction` output 1: IF loads `pc_branch`.
- `pc_branch` output XLEN: predicted target.
- `control_pc` output XLEN: recovery PC.
- `mispredict_cnt` output 16: mispredict event counter.

## Operation
- IF priority is flush > NOP > prediction > pc+4. Outputs are generated consistently with that priority.
- FSM states: INIT, RUN, FLUSH.
- **INIT**
  - Entered on any cycle where `rst` is sampled high. Index counter resets to 0.
  - Each cycle writes 2'b01 (weakly not-taken) into BHT[counter], then increments.
  - After writing entry 2^IDX_W−1, moves to RUN. INIT lasts exactly 2^IDX_W cycles after `rst` deasserts.
  - Outputs: NOP=1, flush=0, prediction=0. `ex_valid` is ignored.
- **RUN**
  - NOP = `load_use` | ~`imem_ready`.
  - prediction = `if_is_branch` & BHT[`if_pc` idx][1] & ~NOP. BHT read is combinational.
  - `pc_branch` = `if_branch_target` (passthrough, all states).
  - On `ex_valid`: update BHT[`ex_pc` idx] as a saturating counter: +1 if `ex_taken`, −1 otherwise, saturating at 2'b11 and 2'b00.
  - Mispredict = `ex_valid` & (`ex_taken` != `ex_pred`). On mispredict:
    - register `control_pc` = `ex_taken` ? `ex_target` : `ex_pc`+4;
    - increment `mispredict_cnt` (wraps 0xFFFF→0);
    - go to FLUSH.
- **FLUSH** (exactly 1 cycle)
  - Outputs: flush=1, NOP=0, prediction=0.
  - `ex_valid` is ignored (wrong-path instruction): no BHT update, no count.
  - Always returns to RUN.
- Same-cycle BHT read and write to the same index: the read returns the old value.
- `control_pc` holds its last value outside FLUSH.

## Timing
- Reset values, visible from the first edge with `rst`=1 and held through INIT: NOP=1, flush=0, prediction=0, `control_pc`=0, `mispredict_cnt`=0, state=INIT. The BHT is overwritten during INIT.
- Prediction latency: 0 cycles (combinational from `if_pc`/`if_is_branch`).
- Mispredict to flush: `ex_valid` mispredict sampled at edge N gives flush=1 during cycle N..N+1. IF loads `control_pc` at edge N+1. flush returns to 0 after edge N+1.
- BHT update is visible to predictions from the cycle after the `ex_valid` edge.
- `load_use` or ~`imem_ready` during FLUSH: flush=1, NOP=0. The stall takes effect in the next RUN cycle.
- `rst` mid-FLUSH or mid-INIT: the next state is INIT, flush=0, and the index counter restarts at 0.

## Test plan
- **Reset/INIT:** rst=1 for 2 cycles, then 0. NOP=1 for exactly 16 cycles after deassert, then 0 (load_use=0, imem_ready=1). flush=0, prediction=0, mispredict_cnt=0 throughout.
- **Training:** ex_valid with ex_pc=100, ex_taken=1, ex_pred=0, ex_target=200. Next cycle: flush=1, control_pc=200, mispredict_cnt=1. Then if_pc=100, if_is_branch=1, if_branch_target=200 gives prediction=1, pc_branch=200. Three more taken updates leave the counter saturated at 2'b11.
- **Not-taken mispredict:** ex_pc=100, ex_pred=1, ex_taken=0 gives flush=1, control_pc=104, mispredict_cnt increments. Holding ex_valid high (mispredicting) through the FLUSH cycle produces no second flush and no count change.
- **Stalls:** predicted-taken branch at if_pc with load_use=1 gives NOP=1, prediction=0. Same with imem_ready=0. Releasing the stall restores prediction=1.
- **Simultaneous:** FLUSH cycle with load_use=1 gives flush=1, NOP=0. Next cycle NOP=1, flush=0.
- **Reset mid-operation:** assert rst during FLUSH. flush=0 after that edge and NOP=1 for 16 cycles after deassert. Afterwards if_pc=100 (previously trained taken) gives prediction=0.
